// File: rtl/phase_decoder.sv
// phase_decoder: samples the {instr_clock, mem_clock} phase pair from the
// multi-phase clock generator and turns the four-phase ring into one-cycle
// stage strobes. It also watches the ring for illegal transitions and stalls,
// and counts completed instruction cycles.
module phase_decoder #(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 instr_clock,
  input  logic                 mem_clock,
  input  logic                 clear_error,
  output logic                 decode_stb,
  output logic                 load_stb,
  output logic                 exec_stb,
  output logic                 fetch_stb,
  output logic                 locked,
  output logic                 seq_error,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    UNSYNC = 3'd0,
    S_IDLE = 3'd1,
    S_IH   = 3'd2,
    S_MH   = 3'd3,
    S_ML   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [3:0]           stb_q, stb_d;      // {decode, load, exec, fetch}
  logic                 locked_q, locked_d;
  logic                 seqError_q, seqError_d;
  logic [1:0]           errCode_q, errCode_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [1:0] pair;
  logic [1:0] holdPair;
  logic [1:0] advPair;
  logic [3:0] advStb;
  state_e     advState;
  logic       holdCounts;
  logic       errEvent;
  logic [1:0] errNew;

  assign pair = {instr_clock, mem_clock};

  // Per-state ring table: which pair is a hold, which pair advances, where the
  // advance goes and which strobe it fires.
  always_comb begin
    holdPair   = 2'b00;
    advPair    = 2'b10;
    advState   = S_IH;
    advStb     = 4'b0000;
    holdCounts = 1'b0;
    case (state_q)
      S_IDLE: begin
        holdPair   = 2'b00;
        advPair    = 2'b10;
        advState   = S_IH;
        advStb     = 4'b1000;
        holdCounts = 1'b0;
      end
      S_IH: begin
        holdPair   = 2'b10;
        advPair    = 2'b11;
        advState   = S_MH;
        advStb     = 4'b0100;
        holdCounts = 1'b1;
      end
      S_MH: begin
        holdPair   = 2'b11;
        advPair    = 2'b10;
        advState   = S_ML;
        advStb     = 4'b0010;
        holdCounts = 1'b1;
      end
      S_ML: begin
        holdPair   = 2'b10;
        advPair    = 2'b00;
        advState   = S_IDLE;
        advStb     = 4'b0001;
        holdCounts = 1'b1;
      end
      default: begin
        holdPair   = 2'b00;
        advPair    = 2'b00;
        advState   = S_IDLE;
        advStb     = 4'b0000;
        holdCounts = 1'b0;
      end
    endcase
  end

  // Next-state decision: resync, advance, hold/timeout or illegal transition,
  // followed by the sticky first-error-wins flag handling.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stb_d    = 4'b0000;
    locked_d = locked_q;
    count_d  = count_q;
    errEvent = 1'b0;
    errNew   = ERR_NONE;

    if (state_q == UNSYNC) begin
      hold_d = '0;
      if (pair == 2'b00) begin
        state_d = S_IDLE;
      end
    end else if (pair == advPair) begin
      state_d = advState;
      stb_d   = advStb;
      hold_d  = '0;
      if (state_q == S_ML) begin
        locked_d = 1'b1;
        count_d  = count_q + CNT_WIDTH'(1);
      end
    end else if (pair == holdPair) begin
      if (holdCounts) begin
        if (hold_q == HOLD_LAST) begin
          errEvent = 1'b1;
          errNew   = ERR_TIMEOUT;
          state_d  = UNSYNC;
          locked_d = 1'b0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end else begin
      errEvent = 1'b1;
      errNew   = ERR_ILLEGAL;
      state_d  = UNSYNC;
      locked_d = 1'b0;
      hold_d   = '0;
    end

    seqError_d = seqError_q;
    errCode_d  = errCode_q;
    if (errEvent) begin
      seqError_d = 1'b1;
      if (!seqError_q || clear_error) begin
        errCode_d = errNew;
      end
    end else if (clear_error) begin
      seqError_d = 1'b0;
      errCode_d  = ERR_NONE;
    end
  end

  // State and registered outputs, all cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNSYNC;
      hold_q     <= '0;
      stb_q      <= 4'b0000;
      locked_q   <= 1'b0;
      seqError_q <= 1'b0;
      errCode_q  <= ERR_NONE;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stb_q      <= stb_d;
      locked_q   <= locked_d;
      seqError_q <= seqError_d;
      errCode_q  <= errCode_d;
      count_q    <= count_d;
    end
  end

  assign decode_stb  = stb_q[3];
  assign load_stb    = stb_q[2];
  assign exec_stb    = stb_q[1];
  assign fetch_stb   = stb_q[0];
  assign locked      = locked_q;
  assign seq_error   = seqError_q;
  assign err_code    = errCode_q;
  assign cycle_count = count_q;

endmodule
